uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that turns the asynchronous serial input line into byte-wide receive strobes for the UART protocol engine (`i_uart_received_pulse` / `i_uart_dat`). It synchronises the line, detects and validates the start bit, samples 8 data bits LSB-first at bit centre, and checks the stop bit. Format is fixed 8N1. Baud timing comes from an integer clock divider derived from parameters.

## Interface
- `SYS_FREQ`, default 25_000_000: system clock frequency in Hz.
- `BAUDRATE`, default 115200: line rate in baud. Derived `TICKS = SYS_FREQ / BAUDRATE` (truncating) and `HALF = TICKS / 2`. `TICKS >= 8` is required.
- `i_clk` input 1: system clock; the single clock.
- `i_reset` input 1: reset, synchronous and active-high.
- `i_rx` input 1: asynchronous serial line; idle high.
- `o_dat` output 8: last correctly received byte.
- `o_received_pulse` output 1: one-cycle strobe; `o_dat` is valid in that cycle.
- `o_frame_error` output 1: one-cycle strobe when the stop bit is sampled low.
- `o_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `i_rx` passes through a 2-FF synchroniser; the result is `rx_s`. The synchroniser registers reset to 1.
- A bit-timing counter counts from 0 to `TICKS-1`. Its sample point is the cycle where count equals `HALF-1` in START, and `TICKS-1` in DATA and STOP.
- FSM states:
  - IDLE: when `rx_s == 0`, clear the counter and enter START.
  - START: at the sample point, `rx_s == 0` enters DATA with bit index 0. `rx_s == 1` is a glitch and returns to IDLE with no output.
  - DATA: at each sample point, shift the sampled bit into the byte, LSB first. After bit 7, enter STOP.
  - STOP: at the sample point, `rx_s == 1` latches the byte into `o_dat`, pulses `o_received_pulse`, and returns to IDLE. `rx_s == 0` pulses `o_frame_error`, leaves `o_dat` unchanged, and enters BREAK.
  - BREAK: wait until `rx_s == 1`, then go to IDLE. This stops a held-low line (break) from producing spurious frames.
- Reset values: `o_dat = 0x00`, `o_received_pulse = 0`, `o_frame_error = 0`, `o_busy = 0`, FSM in IDLE.
- `o_dat` holds its value until the next good frame.

## Timing
- Start-edge latency: 2 cycles of synchroniser, plus 1 cycle to register IDLE→START.
- Sample times: the start bit is sampled `HALF` cycles after entering START. Each following sample is `TICKS` cycles after the previous one.
- Strobe timing: `o_received_pulse` or `o_frame_error` is registered and asserted in the cycle after the stop-bit sample, for exactly 1 cycle. The two strobes are mutually exclusive.
- Back-to-back frames: the FSM returns to IDLE about half a bit before the stop bit ends. A start edge immediately after a 1-bit stop is therefore caught; no idle gap is required.
- Reset mid-frame: the frame is aborted on the next edge with no strobe. A partially assembled byte never reaches `o_dat`.
- Reset has priority over all state updates in the same cycle.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each sample (start, data, stop) is the majority of `rx_s` at counts sample−2, sample−1 and sample. Any single-cycle glitch inside that window is rejected.
- `UART_RX_MAJORITY_EN` undefined: each sample is the single value of `rx_s` at the sample point.
- Either way, strobe timing is identical.

## Test plan
All scenarios use `SYS_FREQ=1_600_000` and `BAUDRATE=100_000`, giving `TICKS=16` and `HALF=8`.
- Send 0x4C ('L') 8N1: exactly one `o_received_pulse`, `o_dat=0x4C`, `o_frame_error` never high. The pulse occurs at 2+1+8+16·9+1 cycles after the `i_rx` fall, ±1 cycle.
- Send "L1a00" back-to-back with 1 stop bit: 5 pulses with `o_dat` = 0x4C, 0x31, 0x61, 0x30, 0x30.
- Drive `i_rx` low for 4 cycles, then high: no strobes; `o_busy` rises and then returns to 0 within 12 cycles.
- Send 0x55 with stop bit = 0, then hold low for 40 bit times, release, and send 0x52: one `o_frame_error`, `o_dat` stays 0x00, no events during the low period, then one pulse with `o_dat=0x52`.
- Assert `i_reset` for 1 cycle during data bit 3 of 0xA5, then send 0x3C: no strobe for the aborted frame; the next frame yields `o_dat=0x3C`.
- Send 0x00 with a 1-cycle high glitch at the centre of bit 2:
  - with `UART_RX_MAJORITY_EN`, `o_dat=0x00`;
  - without it, `o_dat=0x04`.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side bundle between uart_rx and the UART protocol engine
// Signals:
//   o_dat            - last correctly received byte
//   o_received_pulse - one-cycle strobe, o_dat valid in that cycle
//   o_frame_error    - one-cycle strobe, stop bit sampled low
//   o_busy           - receiver is inside a frame (FSM not idle)
// Modports: master = uart_rx (drives), slave = consumer (reads)
interface uart_rx_if;
    logic [7:0] o_dat;
    logic       o_received_pulse;
    logic       o_frame_error;
    logic       o_busy;
    modport master (output o_dat, output o_received_pulse, output o_frame_error, output o_busy);
    modport slave  (input  o_dat, input  o_received_pulse, input  o_frame_error, input  o_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-FF line synchroniser and centre sampling
// Parameters: SYS_FREQ (Hz), BAUDRATE (baud); TICKS = SYS_FREQ/BAUDRATE must be >= 8
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset
//   i_rx    - asynchronous serial line, idle high
//   bus     - uart_rx_if.master: o_dat, o_received_pulse, o_frame_error, o_busy
// Build option: define UART_RX_MAJORITY_EN to take each sample as the 3-cycle
// majority ending at the sample point instead of a single cycle.
module uart_rx #(
    parameter int SYS_FREQ = 25_000_000,
    parameter int BAUDRATE = 115200
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx,
    uart_rx_if.master   bus
);
    localparam int TICKS = SYS_FREQ / BAUDRATE;
    localparam int HALF  = TICKS / 2;
    localparam int CW    = $clog2(TICKS);
    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] C_END  = CW'(TICKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, dat_n;
    logic          pulse_n, fe_n;
    logic          rx_m, rx_s;
    logic          bit_s;
    logic          at_sample;

`ifdef UART_RX_MAJORITY_EN
    // last two synchronised values; together with rx_s they form the vote window
    logic [1:0] hist;
    always_ff @(posedge i_clk) begin
        if (i_reset)
            hist <= 2'b11;
        else
            hist <= {hist[0], rx_s};
    end
    assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_s = rx_s;
`endif

    // start bit is checked half a bit in; data and stop bits a full bit apart
    assign at_sample = (state == START) ? (cnt == C_HALF) : (cnt == C_END);
    assign bus.o_busy = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        dat_n   = bus.o_dat;
        pulse_n = 1'b0;
        fe_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s)
                    state_n = START;
            end
            START: if (at_sample) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = bit_s ? IDLE : DATA;
            end
            DATA: if (at_sample) begin
                cnt_n   = '0;
                shift_n = {bit_s, shift[7:1]};
                idx_n   = idx + 3'd1;
                state_n = (idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (at_sample) begin
                cnt_n   = '0;
                dat_n   = bit_s ? shift : bus.o_dat;
                pulse_n = bit_s;
                fe_n    = !bit_s;
                state_n = bit_s ? IDLE : BREAK;
            end
            BREAK: begin
                // a held-low line must rise before another start can be seen
                cnt_n   = '0;
                state_n = rx_s ? IDLE : BREAK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_m                 <= 1'b1;
            rx_s                 <= 1'b1;
            state                <= IDLE;
            cnt                  <= '0;
            idx                  <= '0;
            shift                <= '0;
            bus.o_dat            <= '0;
            bus.o_received_pulse <= 1'b0;
            bus.o_frame_error    <= 1'b0;
        end else begin
            rx_m                 <= i_rx;
            rx_s                 <= rx_m;
            state                <= state_n;
            cnt                  <= cnt_n;
            idx                  <= idx_n;
            shift                <= shift_n;
            bus.o_dat            <= dat_n;
            bus.o_received_pulse <= pulse_n;
            bus.o_frame_error    <= fe_n;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at TICKS=16, HALF=8
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   fall_cyc = 0;
    int   fe_n = 0;
    int   both_n = 0;
    logic [7:0] pq[$];
    int         pt[$];

    uart_rx_if bus();

    uart_rx #(.SYS_FREQ(1_600_000), .BAUDRATE(100_000)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_rx    (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_received_pulse) begin
            pq.push_back(bus.o_dat);
            pt.push_back(cyc);
        end
        if (bus.o_frame_error) fe_n++;
        if (bus.o_received_pulse && bus.o_frame_error) both_n++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        pq.delete();
        pt.delete();
        fe_n = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        clear_log();
    endtask

    // line level at cycle t of a 160-cycle 8N1 frame; g marks a 1-cycle inverted glitch
    function automatic logic lvl(input logic [7:0] b, input logic stop, input int g, input int t);
        logic v;
        v = (t < 16) ? 1'b0 : (t < 144) ? b[3'((t - 16) / 16)] : stop;
        return (t == g) ? ~v : v;
    endfunction

    // byte a receiver sampling at the centre of each bit would assemble
    function automatic logic [7:0] model(input logic [7:0] b, input int g);
        logic [7:0] r;
        int s;
        logic a0, a1, a2;
        for (int k = 0; k < 8; k++) begin
            s  = 8 + 16 * (k + 1);
            a0 = lvl(b, 1'b1, g, s - 2);
            a1 = lvl(b, 1'b1, g, s - 1);
            a2 = lvl(b, 1'b1, g, s);
`ifdef UART_RX_MAJORITY_EN
            r[k] = (a0 & a1) | (a0 & a2) | (a1 & a2);
`else
            r[k] = a2;
`endif
        end
        return r;
    endfunction

    task automatic send(input logic [7:0] b, input logic stop, input int g, input int len);
        for (int t = 0; t < len; t++) begin
            rx = lvl(b, stop, g, t);
            if (t == 0) fall_cyc = cyc;
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b0;
        tick(3);
        tests++; if (bus.o_dat !== 8'h00) begin fails++; $display("FAIL reset_dat got %h want 00", bus.o_dat); end
        tests++; if (bus.o_received_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse got %b want 0", bus.o_received_pulse); end
        tests++; if (bus.o_frame_error !== 1'b0) begin fails++; $display("FAIL reset_fe got %b want 0", bus.o_frame_error); end
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        rx  = 1'b1;
        rst = 1'b0;
        tick(4);
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b want 0", bus.o_busy); end
        clear_log();
    endtask

    task automatic test_single();
        int lat;
        clear_log();
        send(8'h4C, 1'b1, -1, 160);
        tick(40);
        tests++;
        if (pq.size() != 1) begin
            fails++; $display("FAIL single_count got %0d want 1", pq.size());
        end else begin
            lat = pt[0] - fall_cyc;
            tests++; if (pq[0] !== 8'h4C) begin fails++; $display("FAIL single_dat got %h want 4c", pq[0]); end
            tests++; if (lat < 155 || lat > 157) begin fails++; $display("FAIL single_latency got %0d want 156+-1", lat); end
        end
        tests++; if (fe_n != 0) begin fails++; $display("FAIL single_fe got %0d want 0", fe_n); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [5];
        msg = '{8'h4C, 8'h31, 8'h61, 8'h30, 8'h30};
        clear_log();
        for (int i = 0; i < 5; i++) send(msg[i], 1'b1, -1, 160);
        rx = 1'b1;
        tick(40);
        tests++;
        if (pq.size() != 5) begin
            fails++; $display("FAIL b2b_count got %0d want 5", pq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++; if (pq[i] !== msg[i]) begin fails++; $display("FAIL b2b_dat[%0d] got %h want %h", i, pq[i], msg[i]); end
            end
        end
        tests++; if (fe_n != 0) begin fails++; $display("FAIL b2b_fe got %0d want 0", fe_n); end
    endtask

    task automatic test_start_glitch();
        logic rose, fell;
        rose = 1'b0;
        fell = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            tick(1);
            if (bus.o_busy) rose = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!fell) begin
                tick(1);
                if (bus.o_busy) rose = 1'b1;
                else if (rose) fell = 1'b1;
            end
        end
        tests++; if (rose !== 1'b1) begin fails++; $display("FAIL glitch_busy_rose got %b want 1", rose); end
        tests++; if (fell !== 1'b1) begin fails++; $display("FAIL glitch_busy_fell got %b want 1", fell); end
        tick(200);
        tests++; if (pq.size() != 0 || fe_n != 0) begin fails++; $display("FAIL glitch_events got %0d/%0d want 0/0", pq.size(), fe_n); end
    endtask

    task automatic test_break();
        do_reset();
        send(8'h55, 1'b0, -1, 160);
        rx = 1'b0;
        tick(640);
        tests++; if (fe_n != 1) begin fails++; $display("FAIL break_fe got %0d want 1", fe_n); end
        tests++; if (pq.size() != 0) begin fails++; $display("FAIL break_pulses got %0d want 0", pq.size()); end
        tests++; if (bus.o_dat !== 8'h00) begin fails++; $display("FAIL break_dat got %h want 00", bus.o_dat); end
        tests++; if (bus.o_busy !== 1'b1) begin fails++; $display("FAIL break_busy_low got %b want 1", bus.o_busy); end
        rx = 1'b1;
        tick(32);
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL break_busy_release got %b want 0", bus.o_busy); end
        clear_log();
        send(8'h52, 1'b1, -1, 160);
        tick(40);
        tests++;
        if (pq.size() != 1) begin
            fails++; $display("FAIL after_break_count got %0d want 1", pq.size());
        end else begin
            tests++; if (pq[0] !== 8'h52) begin fails++; $display("FAIL after_break_dat got %h want 52", pq[0]); end
        end
        tests++; if (fe_n != 0) begin fails++; $display("FAIL after_break_fe got %0d want 0", fe_n); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send(8'hA5, 1'b1, -1, 72);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx  = 1'b1;
        tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", bus.o_busy); end
        tests++; if (bus.o_dat !== 8'h00) begin fails++; $display("FAIL midreset_dat got %h want 00", bus.o_dat); end
        tick(200);
        tests++; if (pq.size() != 0 || fe_n != 0) begin fails++; $display("FAIL midreset_events got %0d/%0d want 0/0", pq.size(), fe_n); end
        send(8'h3C, 1'b1, -1, 160);
        tick(40);
        tests++;
        if (pq.size() != 1) begin
            fails++; $display("FAIL midreset_next_count got %0d want 1", pq.size());
        end else begin
            tests++; if (pq[0] !== 8'h3C) begin fails++; $display("FAIL midreset_next_dat got %h want 3c", pq[0]); end
        end
    endtask

    task automatic test_glitch_data();
        logic [7:0] exp;
        exp = model(8'h00, 56);
        clear_log();
        send(8'h00, 1'b1, 56, 160);
        tick(40);
        tests++;
        if (pq.size() != 1) begin
            fails++; $display("FAIL bitglitch_count got %0d want 1", pq.size());
        end else begin
            tests++; if (pq[0] !== exp) begin fails++; $display("FAIL bitglitch_dat got %h want %h", pq[0], exp); end
        end
    endtask

    task automatic test_random();
        logic [7:0] expq[$];
        logic [7:0] b;
        int gap;
        clear_log();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            expq.push_back(model(b, -1));
            send(b, 1'b1, -1, 160);
            gap = $urandom_range(0, 20);
            rx = 1'b1;
            tick(gap);
        end
        rx = 1'b1;
        tick(40);
        tests++;
        if (pq.size() != expq.size()) begin
            fails++; $display("FAIL random_count got %0d want %0d", pq.size(), expq.size());
        end else begin
            for (int i = 0; i < expq.size(); i++) begin
                tests++; if (pq[i] !== expq[i]) begin fails++; $display("FAIL random_dat[%0d] got %h want %h", i, pq[i], expq[i]); end
            end
        end
        tests++; if (fe_n != 0) begin fails++; $display("FAIL random_fe got %0d want 0", fe_n); end
        tests++; if (both_n != 0) begin fails++; $display("FAIL strobe_exclusive got %0d want 0", both_n); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_single();
        test_back_to_back();
        test_start_glitch();
        test_break();
        test_reset_mid();
        test_glitch_data();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
